// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-unit view of pipeline register fields and the stall/flush/forward controls
interface pipeline_hazard_ctrl_if #(parameter int unsigned CNT_W = 32);
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] ResultSrcE;
   logic RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic halted;
   logic [CNT_W-1:0] stall_cycles, flush_events;
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready,
      input StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, halted, stall_cycles, flush_events
   );
   modport slave (
      input Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, halted, stall_cycles, flush_events
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush/forward control with reset purge, memory-wait timeout and perf counters
module pipeline_hazard_ctrl #(
   parameter int unsigned INIT_CYCLES = 4,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W = 32
) (
   input logic clk,
   input logic rst,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, HALT} state_t;
   state_t state, nxt;
   logic [31:0] init_cnt, wait_cnt;
   logic halted;
   logic [CNT_W-1:0] stall_cycles, flush_events;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, flush_ev;
   logic memwait, lduse;
   function automatic logic [1:0] fwd(input logic [4:0] rs);
      return (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs) ? 2'b10 :
             (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs) ? 2'b01 : 2'b00;
   endfunction
   assign memwait = hz.dmem_req & ~hz.dmem_ready;
   assign lduse = hz.ResultSrcE == 2'b01 && hz.RdE != 5'd0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      flush_ev = 1'b0;
      nxt = state;
      unique case (state)
         INIT: begin
            {stall_f, flush_d, flush_e, flush_w} = 4'b1111;
            if (init_cnt == INIT_CYCLES - 1) nxt = RUN;
         end
         RUN: begin
            if (memwait) begin
               {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
               nxt = MEM_WAIT;
            end else if (lduse) begin
               {stall_f, stall_d, flush_e} = 3'b111;
               flush_d = hz.PCSrcE;
               flush_ev = hz.PCSrcE;
            end else if (hz.PCSrcE) begin
               {flush_d, flush_e, flush_ev} = 3'b111;
            end
         end
         MEM_WAIT: begin
            if (hz.dmem_ready) nxt = RUN;
            else begin
               {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
               if (wait_cnt == MEM_TIMEOUT) nxt = HALT;
            end
         end
         default: {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= INIT;
         init_cnt <= '0;
         wait_cnt <= '0;
         halted <= 1'b0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state <= nxt;
         if (state == INIT) init_cnt <= init_cnt + 32'd1;
         // wait_cnt counts the RUN cycle that first saw the wait as wait cycle 1
         if (state == RUN && memwait) wait_cnt <= 32'd1;
         else if (state == MEM_WAIT) wait_cnt <= hz.dmem_ready ? '0 : wait_cnt + 32'd1;
         if (nxt == HALT) halted <= 1'b1;
         if (state != INIT && stall_f && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
         if (flush_ev && !(&flush_events)) flush_events <= flush_events + 1'b1;
      end
   end
   assign hz.StallF = stall_f;
   assign hz.StallD = stall_d;
   assign hz.StallE = stall_e;
   assign hz.StallM = stall_m;
   assign hz.FlushD = flush_d;
   assign hz.FlushE = flush_e;
   assign hz.FlushW = flush_w;
   assign hz.ForwardAE = fwd(hz.Rs1E);
   assign hz.ForwardBE = fwd(hz.Rs2E);
   assign hz.halted = halted;
   assign hz.stall_cycles = stall_cycles;
   assign hz.flush_events = flush_events;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for forwarding/hazard decode plus reset, memory-wait, timeout and saturation sequences
module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst2 = 1'b0;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   pipeline_hazard_ctrl_if #(.CNT_W(32)) mif ();
   pipeline_hazard_ctrl_if #(.CNT_W(3)) sif ();
   pipeline_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(mif.slave));
   pipeline_hazard_ctrl #(.INIT_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(3)) dut_s (.clk(clk), .rst(rst2), .hz(sif.slave));
   // control bit order: StallF StallD StallE StallM FlushD FlushE FlushW
   logic [6:0] mc, sc;
   assign mc = {mif.StallF, mif.StallD, mif.StallE, mif.StallM, mif.FlushD, mif.FlushE, mif.FlushW};
   assign sc = {sif.StallF, sif.StallD, sif.StallE, sif.StallM, sif.FlushD, sif.FlushE, sif.FlushW};
   localparam logic [6:0] C_INIT = 7'b1000111, C_HOLD = 7'b1111001, C_LDU = 7'b1100010,
                          C_LDR = 7'b1100110, C_RED = 7'b0000110, C_NONE = 7'b0000000;
   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic [1:0] rsrc;
      logic rwm, rww, pcs, req, rdy;
      logic [6:0] ctrl;
      logic [1:0] fa, fb;
      logic fev;
   } vec_t;
   vec_t v[13];
   int exp_stall = 0;
   int exp_flush = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic apply(input vec_t x);
      mif.Rs1D = x.rs1d; mif.Rs2D = x.rs2d; mif.Rs1E = x.rs1e; mif.Rs2E = x.rs2e;
      mif.RdE = x.rde; mif.RdM = x.rdm; mif.RdW = x.rdw; mif.ResultSrcE = x.rsrc;
      mif.RegWriteM = x.rwm; mif.RegWriteW = x.rww; mif.PCSrcE = x.pcs;
      mif.dmem_req = x.req; mif.dmem_ready = x.rdy;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      v[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00, 1'b0};
      v[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'b10, 2'b00, 1'b0};
      v[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'b01, 2'b00, 1'b0};
      v[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00, 1'b0};
      v[4]  = '{5'd0, 5'd0, 5'd1, 5'd9, 5'd0, 5'd9, 5'd9, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b01, 1'b0};
      v[5]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'b10, 2'b10, 1'b0};
      v[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_LDU, 2'b00, 2'b00, 1'b0};
      v[7]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_LDR, 2'b00, 2'b00, 1'b1};
      v[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_RED, 2'b00, 2'b00, 1'b1};
      v[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00, 1'b0};
      v[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00, 1'b0};
      v[11] = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_LDU, 2'b00, 2'b00, 1'b0};
      v[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 2'b00, 2'b00, 1'b0};
      apply(v[0]);
      {sif.Rs1D, sif.Rs2D, sif.Rs1E, sif.Rs2E, sif.RdE, sif.RdM, sif.RdW} = '0;
      {sif.ResultSrcE, sif.RegWriteM, sif.RegWriteW, sif.PCSrcE, sif.dmem_req, sif.dmem_ready} = '0;
      // reset purge: four INIT cycles, then idle RUN
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("init_ctrl[%0d]", i), 32'(mc), 32'(i < 4 ? C_INIT : C_NONE));
         step();
      end
      chk("init_stall_cycles", mif.stall_cycles, 0);
      chk("init_flush_events", mif.flush_events, 0);
      chk("init_halted", 32'(mif.halted), 0);
      for (int i = 0; i < 13; i++) begin
         apply(v[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_ctrl", i), 32'(mc), 32'(v[i].ctrl));
         chk($sformatf("vec%0d_fa", i), 32'(mif.ForwardAE), 32'(v[i].fa));
         chk($sformatf("vec%0d_fb", i), 32'(mif.ForwardBE), 32'(v[i].fb));
         exp_stall += int'(v[i].ctrl[6]);
         exp_flush += int'(v[i].fev);
         step();
      end
      apply(v[0]);
      chk("vec_stall_cycles", mif.stall_cycles, 32'(exp_stall));
      chk("vec_flush_events", mif.flush_events, 32'(exp_flush));
      // memory wait: redirect and load-use presented alongside must be ignored
      mif.dmem_req = 1'b1; mif.PCSrcE = 1'b1; mif.ResultSrcE = 2'b01; mif.RdE = 5'd7; mif.Rs2D = 5'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mw_ctrl[%0d]", i), 32'(mc), 32'(C_HOLD));
         step();
         mif.PCSrcE = 1'b0; mif.ResultSrcE = 2'b00;
      end
      mif.dmem_ready = 1'b1;
      @(negedge clk);
      chk("mw_ready_ctrl", 32'(mc), 32'(C_NONE));
      step();
      mif.dmem_req = 1'b0; mif.dmem_ready = 1'b0;
      @(negedge clk);
      chk("mw_after_ctrl", 32'(mc), 32'(C_NONE));
      chk("mw_stall_cycles", mif.stall_cycles, 32'(exp_stall + 3));
      chk("mw_flush_events", mif.flush_events, 32'(exp_flush));
      step();
      // reset while waiting on memory
      mif.dmem_req = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_wait_ctrl", 32'(mc), 32'(C_HOLD));
      step();
      rst = 1'b1; mif.dmem_req = 1'b0;
      @(negedge clk);
      chk("midrst_ctrl", 32'(mc), 32'(C_INIT));
      chk("midrst_stall_cycles", mif.stall_cycles, 0);
      chk("midrst_flush_events", mif.flush_events, 0);
      // timeout with MEM_TIMEOUT=4 on the narrow-counter instance
      step();
      rst2 = 1'b1;
      repeat (4) @(posedge clk);
      #1 sif.dmem_req = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk($sformatf("to_ctrl[%0d]", i), 32'(sc), 32'(C_HOLD));
         chk($sformatf("to_halted[%0d]", i), 32'(sif.halted), 0);
         step();
      end
      @(negedge clk);
      chk("to_halted", 32'(sif.halted), 1);
      step();
      sif.dmem_ready = 1'b1;
      @(negedge clk);
      chk("halt_ready_halted", 32'(sif.halted), 1);
      chk("halt_ready_ctrl", 32'(sc), 32'(C_HOLD));
      step();
      step();
      chk("halt_stall_sat", 32'(sif.stall_cycles), 7);
      rst2 = 1'b0;
      step();
      rst2 = 1'b1; sif.dmem_req = 1'b0; sif.dmem_ready = 1'b0;
      @(negedge clk);
      chk("halt_rst_halted", 32'(sif.halted), 0);
      chk("halt_rst_ctrl", 32'(sc), 32'(C_INIT));
      // flush counter saturation with CNT_W=3
      repeat (4) @(posedge clk);
      #1 sif.PCSrcE = 1'b1;
      repeat (10) @(posedge clk);
      #1 sif.PCSrcE = 1'b0;
      @(negedge clk);
      chk("sat_flush_events", 32'(sif.flush_events), 7);
      chk("sat_stall_cycles", 32'(sif.stall_cycles), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
